// File: rtl/rate_decoder_if.sv
// Pulse-stream side of the rate decoder: the enable stream in, the recovered rate out.
// The decoder takes the slave view; the source/consumer side takes the master view.
interface rate_decoder_if;
    logic       PulseIn;
    logic [1:0] Speed;
    logic       Valid;
    logic       Error;

    modport master (output PulseIn, input Speed, input Valid, input Error);
    modport slave  (input PulseIn, output Speed, output Valid, output Error);
endinterface

// File: rtl/rate_decoder.sv
// Recovers the divider rate code from an enable pulse stream by measuring pulse intervals.
// Locks once two consecutive identical legal intervals are seen; flags bad intervals and stalls.
module rate_decoder #(
    parameter int CLOCK_FREQUENCY = 500
) (
    input  logic          ClockIn,
    input  logic          Resetn,
    rate_decoder_if.slave bus
);

    localparam logic [31:0] F1 = 32'(CLOCK_FREQUENCY);
    localparam logic [31:0] F2 = 32'(2 * CLOCK_FREQUENCY);
    localparam logic [31:0] F4 = 32'(4 * CLOCK_FREQUENCY);

    typedef enum logic [1:0] {IDLE, FIRST, CAND, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [31:0] gap;
    logic [1:0]  cand, cand_nxt;
    logic [1:0]  speed, speed_nxt;
    logic        valid, valid_nxt;
    logic        err, err_nxt;
    logic        pulse;
    logic        legal;
    logic [1:0]  code;

    assign pulse     = bus.PulseIn;
    assign bus.Speed = speed;
    assign bus.Valid = valid;
    assign bus.Error = err;

    // On a pulse cycle gap already holds the distance back to the previous pulse.
    always_comb begin
        legal = 1'b1;
        code  = 2'b00;
        if (gap == 32'd1)    code = 2'b00;
        else if (gap == F1)  code = 2'b01;
        else if (gap == F2)  code = 2'b10;
        else if (gap == F4)  code = 2'b11;
        else                 legal = 1'b0;
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn)
            gap <= '0;
        else if (pulse)
            gap <= 32'd1;
        else if (gap < F4)
            gap <= gap + 32'd1;
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            cand  <= 2'b00;
            speed <= 2'b00;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            speed <= speed_nxt;
            valid <= valid_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        speed_nxt = speed;
        valid_nxt = valid;
        err_nxt   = 1'b0;
        if (pulse) begin
            case (state)
                IDLE: state_nxt = FIRST;
                FIRST: begin
                    if (legal) begin
                        state_nxt = CAND;
                        cand_nxt  = code;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                CAND: begin
                    if (!legal) begin
                        state_nxt = FIRST;
                        err_nxt   = 1'b1;
                    end else if (code == cand) begin
                        state_nxt = LOCKED;
                        speed_nxt = code;
                        valid_nxt = 1'b1;
                    end else begin
                        cand_nxt = code;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        state_nxt = FIRST;
                        valid_nxt = 1'b0;
                        err_nxt   = 1'b1;
                    end else if (code != speed) begin
                        state_nxt = CAND;
                        cand_nxt  = code;
                        valid_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && gap == F4) begin
            // Stalled stream: a pulse landing exactly at 4F is handled above as code 11.
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            err_nxt   = 1'b1;
        end
    end

endmodule

// File: tb/tb_rate_decoder.sv
// Bench for rate_decoder: directed scenarios plus a random pulse stream checked
// against a timestamp-based model of interval locking.
module tb_rate_decoder;
    localparam int F = 4;

    logic ClockIn = 1'b0;
    logic Resetn  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rate_decoder_if bus();

    rate_decoder #(.CLOCK_FREQUENCY(F)) dut (
        .ClockIn (ClockIn),
        .Resetn  (Resetn),
        .bus     (bus)
    );

    always #5 ClockIn = ~ClockIn;

    // Model: remembers when the reference pulse happened and the previous interval's code.
    int         n = 0;
    bit         m_ref;
    int         m_ref_t;
    int         m_prev;
    logic [1:0] m_speed;
    logic       m_valid;
    logic       m_err;

    function automatic int classify(input int d);
        if (d == 1)     return 0;
        if (d == F)     return 1;
        if (d == 2 * F) return 2;
        if (d == 4 * F) return 3;
        return -1;
    endfunction

    task automatic model_reset();
        m_ref   = 1'b0;
        m_ref_t = 0;
        m_prev  = -1;
        m_speed = 2'b00;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_tick(input bit p);
        int c;
        m_err = 1'b0;
        if (p) begin
            if (!m_ref) begin
                m_ref  = 1'b1;
                m_prev = -1;
            end else begin
                c = classify(n - m_ref_t);
                if (c < 0) begin
                    m_err   = 1'b1;
                    m_valid = 1'b0;
                    m_prev  = -1;
                end else begin
                    if (m_prev == c) begin
                        m_valid = 1'b1;
                        m_speed = 2'(c);
                    end else begin
                        m_valid = 1'b0;
                    end
                    m_prev = c;
                end
            end
            m_ref_t = n;
        end else if (m_ref && (n - m_ref_t) == 4 * F) begin
            m_err   = 1'b1;
            m_valid = 1'b0;
            m_ref   = 1'b0;
        end
    endtask

    task automatic step(input bit p);
        bus.PulseIn = p;
        @(posedge ClockIn);
        model_tick(p);
        n++;
        #1;
    endtask

    task automatic do_reset();
        bus.PulseIn = 1'b0;
        Resetn = 1'b0;
        model_reset();
        @(posedge ClockIn);
        #1;
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        bus.PulseIn = 1'b0;
        #1;
        Resetn = 1'b0;
        model_reset();
        #1;
        total++;
        if ({bus.Speed, bus.Valid, bus.Error} !== 4'b0000) begin
            bad++;
            $display("FAIL reset got=%b exp=0000", {bus.Speed, bus.Valid, bus.Error});
        end
        @(posedge ClockIn);
        #1;
        Resetn = 1'b1;
    endtask

    task automatic test_lock_01();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(i % 4 == 0);
            total++;
            if ({bus.Speed, bus.Valid, bus.Error} !== {m_speed, m_valid, m_err}) begin
                bad++;
                $display("FAIL lock01 cyc=%0d got=%b exp=%b", i, {bus.Speed, bus.Valid, bus.Error}, {m_speed, m_valid, m_err});
            end
            if (i == 8) begin
                total++;
                if ({bus.Speed, bus.Valid, bus.Error} !== 4'b0110) begin
                    bad++;
                    $display("FAIL lock01_edge got=%b exp=0110", {bus.Speed, bus.Valid, bus.Error});
                end
            end
        end
    endtask

    task automatic test_continuous();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            total++;
            if ({bus.Speed, bus.Valid, bus.Error} !== {m_speed, m_valid, m_err}) begin
                bad++;
                $display("FAIL contin cyc=%0d got=%b exp=%b", i, {bus.Speed, bus.Valid, bus.Error}, {m_speed, m_valid, m_err});
            end
            if (i == 2) begin
                total++;
                if ({bus.Speed, bus.Valid, bus.Error} !== 4'b0010) begin
                    bad++;
                    $display("FAIL contin_lock got=%b exp=0010", {bus.Speed, bus.Valid, bus.Error});
                end
            end
        end
    endtask

    task automatic test_rate_change();
        do_reset();
        for (int i = 0; i < 27; i++) begin
            step(i == 0 || i == 4 || i == 8 || i == 16 || i == 24);
            total++;
            if ({bus.Speed, bus.Valid, bus.Error} !== {m_speed, m_valid, m_err}) begin
                bad++;
                $display("FAIL ratechg cyc=%0d got=%b exp=%b", i, {bus.Speed, bus.Valid, bus.Error}, {m_speed, m_valid, m_err});
            end
            if (i == 16 || i == 24) begin
                total++;
                if ({bus.Speed, bus.Valid, bus.Error} !== ((i == 16) ? 4'b0100 : 4'b1010)) begin
                    bad++;
                    $display("FAIL ratechg_pt cyc=%0d got=%b", i, {bus.Speed, bus.Valid, bus.Error});
                end
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(i == 0 || i == 4 || i == 8 || i == 13 || i == 17 || i == 21);
            total++;
            if ({bus.Speed, bus.Valid, bus.Error} !== {m_speed, m_valid, m_err}) begin
                bad++;
                $display("FAIL illegal cyc=%0d got=%b exp=%b", i, {bus.Speed, bus.Valid, bus.Error}, {m_speed, m_valid, m_err});
            end
            if (i == 13 || i == 14 || i == 17 || i == 21) begin
                total++;
                if ({bus.Speed, bus.Valid, bus.Error} !==
                    ((i == 13) ? 4'b0101 : (i == 21) ? 4'b0110 : 4'b0100)) begin
                    bad++;
                    $display("FAIL illegal_pt cyc=%0d got=%b", i, {bus.Speed, bus.Valid, bus.Error});
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 66; i++) begin
            step(i == 0 || i == 16 || i == 32 || i == 55 || i == 59 || i == 63);
            total++;
            if ({bus.Speed, bus.Valid, bus.Error} !== {m_speed, m_valid, m_err}) begin
                bad++;
                $display("FAIL timeout cyc=%0d got=%b exp=%b", i, {bus.Speed, bus.Valid, bus.Error}, {m_speed, m_valid, m_err});
            end
            if (i == 47 || i == 48 || i == 49 || i == 59 || i == 63) begin
                total++;
                if ({bus.Speed, bus.Valid, bus.Error} !==
                    ((i == 47) ? 4'b1110 : (i == 48) ? 4'b1101 : (i == 49) ? 4'b1100 :
                     (i == 59) ? 4'b1100 : 4'b0110)) begin
                    bad++;
                    $display("FAIL timeout_pt cyc=%0d got=%b", i, {bus.Speed, bus.Valid, bus.Error});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(i == 0 || i == 4 || i == 8 || i == 12 || i == 16 || i == 20);
            if (i == 10) begin
                Resetn = 1'b0;
                model_reset();
                #1;
                total++;
                if ({bus.Speed, bus.Valid, bus.Error} !== 4'b0000) begin
                    bad++;
                    $display("FAIL async_rst got=%b exp=0000", {bus.Speed, bus.Valid, bus.Error});
                end
                Resetn = 1'b1;
            end
            total++;
            if ({bus.Speed, bus.Valid, bus.Error} !== {m_speed, m_valid, m_err}) begin
                bad++;
                $display("FAIL asyncrst cyc=%0d got=%b exp=%b", i, {bus.Speed, bus.Valid, bus.Error}, {m_speed, m_valid, m_err});
            end
            if (i == 16 || i == 20) begin
                total++;
                if (bus.Valid !== (i == 20)) begin
                    bad++;
                    $display("FAIL relock cyc=%0d valid=%b", i, bus.Valid);
                end
            end
        end
    endtask

    task automatic test_random();
        int left = 1;
        int ivl  = F;
        int r;
        bit p;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                Resetn = 1'b0;
                model_reset();
                #1;
                Resetn = 1'b1;
            end
            left--;
            p = (left == 0);
            if (p) begin
                r = $urandom_range(0, 9);
                if (r >= 6 && r < 8) begin
                    case ($urandom_range(0, 3))
                        0: ivl = 1;
                        1: ivl = F;
                        2: ivl = 2 * F;
                        default: ivl = 4 * F;
                    endcase
                end else if (r >= 8) begin
                    ivl = $urandom_range(1, 5 * F);
                end
                left = ivl;
            end
            step(p);
            total++;
            if ({bus.Speed, bus.Valid, bus.Error} !== {m_speed, m_valid, m_err}) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, {bus.Speed, bus.Valid, bus.Error}, {m_speed, m_valid, m_err});
            end
        end
    endtask

    initial begin
        bus.PulseIn = 1'b0;
        model_reset();
        test_reset();
        test_lock_01();
        test_continuous();
        test_rate_change();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rate_decoder.md
# rate_decoder

Receive-side counterpart to the counters-lab rate divider. It watches a single-cycle enable pulse stream produced at one of the four divider rates and recovers the 2-bit `Speed` code that generated it. It asserts `Valid` once two consecutive identical intervals have been seen. It also flags malformed or stalled streams. It sits between any enable source and the display/debug logic that needs to know the current rate.

## Interface
- `CLOCK_FREQUENCY`, default 500. Base divider period F in cycles. Legal range is ≥ 2, so that interval 1 and interval F are distinct.
- `ClockIn`  in  1  system clock; all state updates on its rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `PulseIn`  in  1  synchronous enable stream; each cycle sampled high counts as one pulse.
- `Speed`  out  2  last locked rate code: 00 → interval 1, 01 → F, 10 → 2F, 11 → 4F.
- `Valid`  out  1  high while locked; `Speed` is current.
- `Error`  out  1  one-cycle registered pulse on an illegal interval or a timeout.

## Operation
- **Gap counter**, 32-bit:
  - Cycle with `PulseIn`=1: Gap ← 1.
  - Otherwise: Gap ← Gap+1, saturating at 4F.
  - At a pulse, Gap holds d = the cycle distance since the previous pulse.
- **Classification of d**:
  - 1 → 00; F → 01; 2F → 10; 4F → 11.
  - Any other value is illegal.
  - Matching is exact; there is no tolerance.
- **State machine**: IDLE, FIRST, CAND, LOCKED. A 2-bit Cand register holds the candidate code.
- **IDLE**
  - Pulse → FIRST.
  - Gap contents are ignored.
- **FIRST**
  - Legal pulse with code c → CAND, Cand ← c.
  - Illegal pulse → stay in FIRST (the new pulse becomes the reference); `Error`=1.
- **CAND**
  - Legal pulse with c == Cand → LOCKED; `Speed` ← c; `Valid` ← 1.
  - Legal pulse with c ≠ Cand → stay in CAND; Cand ← c.
  - Illegal pulse → FIRST; `Error`=1.
- **LOCKED**
  - Legal pulse with c == `Speed` → stay.
  - Legal pulse with c ≠ `Speed` → CAND; Cand ← c; `Valid` ← 0.
  - Illegal pulse → FIRST; `Valid` ← 0; `Error`=1.
- **Timeout**
  - Condition: state ≠ IDLE, no pulse this cycle, and Gap == 4F.
  - Result: next state IDLE; `Valid` ← 0; `Error`=1.
  - A pulse in the same cycle takes priority; that cycle is evaluated as a pulse with d = 4F.
- `Speed` holds its last locked value while `Valid`=0. It changes only on entry to LOCKED.
- `Error` is high for exactly one cycle per event and is never held.

## Timing
- **Reset values** (`Resetn`=0, immediate, asynchronous): state IDLE, Gap 0, Cand 00, `Speed` 00, `Valid` 0, `Error` 0.
- Deasserting `Resetn` mid-stream restarts acquisition from IDLE. The first pulse after reset is only a reference pulse.
- **Latency**: all outputs are registered.
  - `Valid` rises in the cycle after the third pulse of a steady stream is sampled.
  - `Error` appears in the cycle after the offending pulse, or after the timeout cycle.
- **Lock-change latency**: after a rate change, `Valid` drops one cycle after the first differing interval. It re-asserts one cycle after the second matching new interval.
- **Continuous high** (`PulseIn` stuck at 1): d=1 every cycle, so the block locks to 00 after 3 cycles.

## Test plan
- **Lock at 01** (F=4, pulses at cycles 0, 4, 8, 12): `Valid` rises after the cycle-8 edge with `Speed`=01. It stays high; `Error` is never asserted.
- **Continuous high** (F=4, `PulseIn`=1 from cycle 0): `Speed`=00 and `Valid`=1 after the cycle-2 edge.
- **Rate change** (F=4, locked at 01, then intervals of 8, 8): `Valid` drops after the first 8-interval pulse. It re-asserts with `Speed`=10 after the second; no `Error`.
- **Illegal interval** (F=4, locked at 01, one interval of 5): one-cycle `Error`, `Valid`=0, state FIRST. Two further 4-intervals are then needed to re-lock.
- **Timeout** (F=4, locked at 11, then `PulseIn` held low): `Error` pulse and `Valid`=0 exactly 16 cycles after the last pulse. A later pulse starts a new acquisition from IDLE.
- **Async reset mid-lock** (`Resetn` low for 1 ns between edges): `Valid`, `Error`, and `Speed` go to 0 immediately. After release, three pulses are needed to lock again.
